// File: rtl/nandgate_arbiter.sv
// ---------------------------------------------------------------------------
// nandgate_arbiter
//
// Shares one bitwise-NAND datapath (module nandgate, defined below) among
// NREQ requesters using round-robin arbitration. Each transaction runs
// IDLE (grant) -> CALC (compute) -> RESP (hold until accepted).
//
// Parameters:
//   WIDTH  operand/result width
//   NREQ   number of requesters (2..8)
//   IDW    response ID width (2**IDW >= NREQ)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]        per-requester operand pair pending
//   req_a      [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand B, same packing
//   req_ready  [NREQ]        one-hot grant (combinational, IDLE only)
//   rsp_valid                result available
//   rsp_ready                consumer accepts result
//   rsp_data   [WIDTH]       ~(a & b) of the granted pair
//   rsp_id     [IDW]         index of the requester that produced rsp_data
//   busy                     high whenever the FSM is not in IDLE
//   busy_cnt   [32]          saturating count of non-IDLE cycles; present
//                            only when NANDGATE_ARB_BUSYCNT_EN is defined
// ---------------------------------------------------------------------------

module nandgate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a & b);

endmodule

module nandgate_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
`ifdef NANDGATE_ARB_BUSYCNT_EN
  ,
  output logic [31:0]           busy_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] nand_y;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand   = IDW'((int'(ptr) + k) % NREQ);
      // Only the first hit in search order may update the winner.
      winner = (!found && req_valid[cand]) ? cand : winner;
      found  = found | req_valid[cand];
    end
  end

  // Operand select for the current winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a = (winner == IDW'(i)) ? req_a[i*WIDTH +: WIDTH] : sel_a;
      sel_b = (winner == IDW'(i)) ? req_b[i*WIDTH +: WIDTH] : sel_b;
    end
  end

  // One-hot grant, only in IDLE; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n & found & (state == IDLE) & (winner == IDW'(i));
    end
  end

  nandgate #(.WIDTH(WIDTH)) u_nandgate (
    .a (op_a),
    .b (op_b),
    .y (nand_y)
  );

  // Transaction FSM, round-robin pointer, granted ID and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      id_q  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= CALC;
            id_q  <= winner;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            // Next search starts just past the requester we served.
            ptr   <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers, loaded on the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == IDLE && found) begin
      op_a <= sel_a;
      op_b <= sel_b;
    end
  end

  // Response registers: captured in CALC, held in RESP until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        CALC: begin
          rsp_valid <= 1'b1;
          rsp_data  <= nand_y;
          rsp_id    <= id_q;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef NANDGATE_ARB_BUSYCNT_EN
  // Saturating count of edges spent outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 32'd0;
    end else if (state != IDLE && busy_cnt != 32'hFFFF_FFFF) begin
      busy_cnt <= busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/nandgate_arbiter.md
# nandgate_arbiter

Round-robin controller that shares one `nandgate` datapath instance among NREQ requesters. Each requester presents a WIDTH-bit operand pair through a valid/ready handshake. The block grants one requester at a time, registers its operands, computes the bitwise NAND, and returns the result with the requester's ID through a valid/ready response channel. It sits between the operand-producing masters and the shared logic unit; the `nandgate` instance lives inside this block.

## Interface
- WIDTH, 32, operand/result width; passed to the internal `nandgate #(WIDTH)`
- NREQ, 4, number of requesters; legal range 2..8
- IDW, 2, width of the response ID; 2**IDW >= NREQ required
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_a  in  NREQ*WIDTH  requester i operand A at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  requester i operand B, same packing
- req_ready  out  NREQ  one-hot grant; bit i high means requester i's pair is accepted this cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  WIDTH  ~(a & b) of the granted pair
- rsp_id  out  IDW  index of the requester that produced rsp_data
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - CALC: operands registered; NAND output being captured.
  - RESP: result presented; waiting for rsp_ready.
- IDLE: if any req_valid bit is set, the winner is the first set bit searching from index ptr upward, wrapping NREQ-1 -> 0.
  - req_ready[winner] is asserted combinationally in the same cycle.
  - On that edge: op_a/op_b capture the winner's operands, id_q captures the winner index, and the FSM goes to CALC.
  - With no valid request, req_ready = 0 and the FSM stays in IDLE.
- CALC: rsp_data <= nandgate(op_a, op_b), rsp_id <= id_q, rsp_valid <= 1; go to RESP. Unconditional, one cycle.
- RESP: rsp_valid, rsp_data and rsp_id are held stable while rsp_ready = 0.
  - On rsp_ready = 1: rsp_valid <= 0, ptr <= (id_q + 1) mod NREQ, go to IDLE.
- req_ready is zero in CALC and RESP; at most one bit is ever high.
- Requesters hold valid and operands stable until granted. Dropping valid before the grant is legal and simply removes the requester from arbitration.
- Simultaneous requests from all NREQ requesters are served in order ptr, ptr+1, ... with no starvation. The worst-case wait is NREQ-1 transactions.
- ptr wrap: a grant to NREQ-1 sets ptr to 0.
- Reset values: state = IDLE, ptr = 0, op_a = op_b = 0, id_q = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, req_ready = 0, busy = 0.
- Reset asserted mid-transaction clears all state immediately, with no clock needed. The in-flight result is discarded. The first grant after reset goes to the lowest-index valid requester.

## Timing
- Grant at edge T (IDLE, req_ready high); rsp_valid rises after edge T+1. Request-to-response latency is 2 cycles.
- With rsp_ready held high, the next grant is possible at edge T+3. Peak throughput is 1 operation per 3 cycles.
- Back-pressure: each cycle with rsp_ready low adds one cycle; nothing is lost.
- rsp_ready sampled high in the same cycle rsp_valid rises completes the response at that edge.
- req_ready is a combinational function of state, ptr and req_valid. No combinational path exists from rsp_ready to any output.

## Configuration
- NANDGATE_ARB_BUSYCNT_EN defined: adds output port busy_cnt (out, 32).
  - busy_cnt increments on every clock edge where state != IDLE.
  - It saturates at 32'hFFFFFFFF and resets to 0 on rst_n low.
- Macro undefined: busy_cnt port and counter logic are absent. All other behaviour is identical.

## Test plan
- Single request: requester 0 with a = 32'hA5A5A5A5, b = 32'h5A5A5A5A -> req_ready = 4'b0001 for 1 cycle; rsp_valid 2 cycles later with rsp_data = 32'hFFFFFFFF, rsp_id = 0.
- All four requesters valid from reset, rsp_ready = 1:
  - Requester 1 uses a = b = 32'hFFFFFFFF; requester 2 uses a = 32'hFFFF0000, b = 32'hFF00FF00.
  - Required: grants in order 0, 1, 2, 3, 3 cycles apart; rsp_data 32'h00000000 for id 1 and 32'h00FFFFFF for id 2.
- Back-pressure: hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable; req_ready = 0 throughout; busy = 1.
- Wrap: ptr = 3 after a grant to requester 2; requesters 0 and 3 valid -> requester 3 granted first, then 0.
- Reset mid-op: drop rst_n during RESP -> rsp_valid, busy and req_ready go to 0 immediately; after release with requesters 2 and 0 valid, requester 0 is granted first.
- With NANDGATE_ARB_BUSYCNT_EN: 2 back-to-back transactions with rsp_ready = 1 -> busy_cnt = 4.
